cacheline_burst_adaptor: RTL and testbench

// - Sits directly downstream of the I-cache controller (and its prefetch path) on the pmem_* interface.
// - Converts one 256-bit cache-line read or write into a 4-beat, 64-bit burst on the physical memory bus.
// - Returns pmem_resp to the cache only when the whole line has moved.

---
 rtl/cacheline_burst_adaptor.sv | 94 +++++++++
 tb/tb_cacheline_burst_adaptor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - splits one cache-line read/write into a fixed-length beat burst
module cacheline_burst_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  wdata_q;

    // The write line is captured once at acceptance so the cache side may change freely mid-burst.
    assign mem_wdata = wdata_q[cnt * BEAT_W +: BEAT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wdata_q     <= '0;
            pmem_rdata  <= '0;
            pmem_resp   <= 1'b0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pmem_resp <= 1'b0;
                    if (pmem_write) begin
                        mem_address <= {pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        wdata_q     <= pmem_wdata;
                        cnt         <= '0;
                        mem_write   <= 1'b1;
                        state       <= WRITE;
                    end else if (pmem_read) begin
                        mem_address <= {pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        cnt         <= '0;
                        mem_read    <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (mem_resp) begin
                        pmem_rdata[cnt * BEAT_W +: BEAT_W] <= mem_rdata;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            mem_read  <= 1'b0;
                            pmem_resp <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_resp) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            mem_write <= 1'b0;
                            pmem_resp <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    pmem_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb/tb_cacheline_burst_adaptor.sv - directed self-checking bench for cacheline_burst_adaptor
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] A0 = 64'hAAAA_0000_0000_00A0, A1 = 64'hAAAA_1111_0000_00A1;
    localparam logic [63:0] A2 = 64'hAAAA_2222_0000_00A2, A3 = 64'hAAAA_3333_0000_00A3;
    localparam logic [63:0] B0 = 64'hBBBB_0000_0000_00B0, B1 = 64'hBBBB_1111_0000_00B1;
    localparam logic [63:0] B2 = 64'hBBBB_2222_0000_00B2, B3 = 64'hBBBB_3333_0000_00B3;
    localparam logic [63:0] C0 = 64'hCCCC_0000_0000_00C0, C1 = 64'hCCCC_1111_0000_00C1;
    localparam logic [63:0] C2 = 64'hCCCC_2222_0000_00C2, C3 = 64'hCCCC_3333_0000_00C3;
    localparam logic [63:0] D0 = 64'hDDDD_0000_0000_00D0, D1 = 64'hDDDD_1111_0000_00D1;
    localparam logic [63:0] D2 = 64'hDDDD_2222_0000_00D2, D3 = 64'hDDDD_3333_0000_00D3;
    localparam logic [63:0] E0 = 64'hEEEE_0000_0000_00E0, E1 = 64'hEEEE_1111_0000_00E1;
    localparam logic [63:0] F0 = 64'hFFFF_0000_0000_00F0, F1 = 64'hFFFF_1111_0000_00F1;
    localparam logic [63:0] F2 = 64'hFFFF_2222_0000_00F2, F3 = 64'hFFFF_3333_0000_00F3;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    localparam logic [63:0] W0 = 64'h8796_A5B4_C3D2_E1F0, W1 = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] W2 = 64'hFEDC_BA98_7654_3210, W3 = 64'h0123_4567_89AB_CDEF;

    cacheline_burst_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d);
        mem_resp  = 1'b1;
        mem_rdata = d;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = JUNK;
    endtask

    task automatic stall();
        mem_resp = 1'b0;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pmem_resp"}, pmem_resp, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_pmem_rdata"}, pmem_rdata, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        rst = 1'b1; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;

        // mem_resp while idle must not capture anything
        beat(JUNK);
        chk("idle_resp_rdata", pmem_rdata, 0);
        chk("idle_resp_mem_read", mem_read, 0);

        // plain read at an unaligned address
        pmem_address = 32'h0000_1234; pmem_read = 1'b1;
        tick();
        chk("rd_mem_read", mem_read, 1);
        chk("rd_mem_address", mem_address, 32'h0000_1220);
        chk("rd_resp_low", pmem_resp, 0);
        beat(A0); beat(A1); beat(A2);
        chk("rd_no_early_resp", pmem_resp, 0);
        beat(A3);
        chk("rd_resp", pmem_resp, 1);
        chk("rd_line", pmem_rdata, {A3, A2, A1, A0});
        chk("rd_mem_read_drop", mem_read, 0);
        pmem_read = 1'b0;
        tick();
        chk("rd_resp_one_cycle", pmem_resp, 0);

        // write with one gap after the first beat
        pmem_address = 32'h8000_0040; pmem_wdata = {W3, W2, W1, W0}; pmem_write = 1'b1;
        tick();
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_address", mem_address, 32'h8000_0040);
        chk("wr_beat0", mem_wdata, W0);
        mem_resp = 1'b1; tick();
        chk("wr_beat1", mem_wdata, W1);
        stall();
        chk("wr_beat1_held", mem_wdata, W1);
        chk("wr_mem_write_held", mem_write, 1);
        mem_resp = 1'b1; tick();
        chk("wr_beat2", mem_wdata, W2);
        chk("wr_no_early_resp", pmem_resp, 0);
        tick();
        chk("wr_beat3", mem_wdata, W3);
        tick();
        mem_resp = 1'b0;
        chk("wr_resp", pmem_resp, 1);
        chk("wr_mem_write_drop", mem_write, 0);
        chk("wr_keeps_rdata", pmem_rdata, {A3, A2, A1, A0});
        pmem_write = 1'b0;
        tick();

        // stalled read, pattern 1,0,0,1,0,1,1; request dropped mid-burst
        pmem_address = 32'h0000_2000; pmem_read = 1'b1;
        tick();
        pmem_read = 1'b0;
        beat(B0); stall(); stall();
        chk("st_mem_read_held", mem_read, 1);
        chk("st_no_early_resp", pmem_resp, 0);
        chk("st_partial", pmem_rdata, {A3, A2, A1, B0});
        beat(B1); stall();
        chk("st_mem_read_held2", mem_read, 1);
        beat(B2);
        chk("st_no_early_resp2", pmem_resp, 0);
        beat(B3);
        chk("st_resp", pmem_resp, 1);
        chk("st_line", pmem_rdata, {B3, B2, B1, B0});
        tick();

        // back-to-back: read, prefetch read, write
        pmem_address = 32'h0000_3000; pmem_read = 1'b1;
        tick();
        beat(C0); beat(C1); beat(C2); beat(C3);
        chk("bb1_resp", pmem_resp, 1);
        pmem_address = 32'h0000_3020;
        tick();
        chk("bb2_not_in_done", mem_read, 0);
        chk("bb2_resp_low", pmem_resp, 0);
        tick();
        chk("bb2_accepted", mem_read, 1);
        chk("bb2_address", mem_address, 32'h0000_3020);
        stall();
        chk("bb2_rdata_held", pmem_rdata, {C3, C2, C1, C0});
        beat(D0);
        chk("bb2_first_beat", pmem_rdata, {C3, C2, C1, D0});
        beat(D1); beat(D2); beat(D3);
        chk("bb2_resp", pmem_resp, 1);
        chk("bb2_line", pmem_rdata, {D3, D2, D1, D0});
        pmem_read = 1'b0; pmem_write = 1'b1; pmem_address = 32'h0000_3040;
        tick();
        chk("bb3_not_in_done", mem_write, 0);
        tick();
        chk("bb3_accepted", mem_write, 1);
        chk("bb3_address", mem_address, 32'h0000_3040);
        mem_resp = 1'b1;
        tick(); tick(); tick(); tick();
        mem_resp = 1'b0;
        chk("bb3_resp", pmem_resp, 1);
        chk("bb3_keeps_rdata", pmem_rdata, {D3, D2, D1, D0});
        pmem_write = 1'b0;
        tick();

        // simultaneous requests: write wins
        pmem_address = 32'h0000_501F; pmem_read = 1'b1; pmem_write = 1'b1;
        tick();
        chk("sim_mem_write", mem_write, 1);
        chk("sim_mem_read", mem_read, 0);
        chk("sim_address", mem_address, 32'h0000_5000);
        pmem_read = 1'b0; pmem_write = 1'b0;
        mem_resp = 1'b1;
        tick(); tick(); tick(); tick();
        mem_resp = 1'b0;
        chk("sim_resp", pmem_resp, 1);
        tick();

        // reset after two read beats, then a clean read
        pmem_address = 32'h0000_4000; pmem_read = 1'b1;
        tick();
        pmem_read = 1'b0;
        beat(E0); beat(E1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        pmem_address = 32'h0000_4000; pmem_read = 1'b1;
        tick();
        chk("post_rst_address", mem_address, 32'h0000_4000);
        chk("post_rst_mem_read", mem_read, 1);
        pmem_read = 1'b0;
        beat(F0); beat(F1); beat(F2);
        chk("post_rst_no_early", pmem_resp, 0);
        beat(F3);
        chk("post_rst_resp", pmem_resp, 1);
        chk("post_rst_line", pmem_rdata, {F3, F2, F1, F0});
        tick();
        chk("post_rst_resp_low", pmem_resp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
